// File: rtl/register_access_controller.sv
// rtl/register_access_controller.sv - UART packet to register bus access engine
//
// Purpose:
//   Decodes UART_PACKET byte streams into register reads and writes.
//   Read command  : single-byte packet (SoP=EoP=1) to READ_DEST, Data = address.
//                   Answered with a DATA_BYTES-byte packet, MSB first.
//   Write command : address byte (SoP=1) to WRITE_DEST followed by DATA_BYTES
//                   data bytes, MSB first, EoP on the last; committed with a
//                   one-cycle opWrEnable strobe.
//
// Ports:
//   ipClk        system clock, rising edge
//   ipReset      synchronous active-high reset
//   ipRxStream   received bytes, no backpressure
//   opTxStream   response bytes, held stable until ipTxReady
//   ipTxReady    transmitter accepts opTxStream this cycle
//   opAddress    register address
//   ipReadData   register read data, valid one cycle after opAddress
//   opWriteData  write word
//   opWrEnable   one-cycle write strobe
//
// Configuration macro:
//   WRITE_ACK_EN  when defined, each committed write is acknowledged with a
//                 one-byte packet carrying the address byte.

package uart_packet_pkg;
    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;
endpackage

module register_access_controller
    import uart_packet_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] READ_DEST  = 8'h00,
    parameter logic [7:0] WRITE_DEST = 8'h01
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  UART_PACKET              ipRxStream,
    output UART_PACKET              opTxStream,
    input  logic                    ipTxReady,
    output logic [ADDR_WIDTH-1:0]   opAddress,
    input  logic [8*DATA_BYTES-1:0] ipReadData,
    output logic [8*DATA_BYTES-1:0] opWriteData,
    output logic                    opWrEnable
);
    localparam int DATA_WIDTH = 8 * DATA_BYTES;
    localparam int CNT_WIDTH  = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_INDEX = CNT_WIDTH'(DATA_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DATA_BYTES);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] RX_WRITE     = 3'd1;
    localparam logic [2:0] READ_WAIT    = 3'd2;
    localparam logic [2:0] READ_LATCH   = 3'd3;
    localparam logic [2:0] TX_DATA      = 3'd4;
    localparam logic [2:0] WRITE_COMMIT = 3'd5;
`ifdef WRITE_ACK_EN
    localparam logic [2:0] TX_ACK       = 3'd6;
`endif

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [CNT_WIDTH-1:0]  byteIndex;
    logic [CNT_WIDTH-1:0]  byteCount;
    logic [7:0]            srcLatch;
`ifdef WRITE_ACK_EN
    logic [7:0]            addrByte;
`endif

    logic                  isReadCmd;
    logic                  isWriteCmd;
    logic                  restartCmd;
    logic [CNT_WIDTH-1:0]  countNext;
    logic [DATA_WIDTH-1:0] shiftedWrite;
    logic                  unusedRx;

    assign isReadCmd  = ipRxStream.Valid && ipRxStream.SoP && ipRxStream.EoP
                        && (ipRxStream.Destination == READ_DEST);
    assign isWriteCmd = ipRxStream.Valid && ipRxStream.SoP && !ipRxStream.EoP
                        && (ipRxStream.Destination == WRITE_DEST);
    // A SoP inside a write packet abandons it and is decoded like a fresh byte.
    assign restartCmd = (state == RX_WRITE) && ipRxStream.Valid && ipRxStream.SoP;
    assign countNext    = byteCount + CNT_WIDTH'(1);
    assign shiftedWrite = (opWriteData << 8) | DATA_WIDTH'(ipRxStream.Data);
    // The incoming Length field carries nothing this block needs.
    assign unusedRx = ^ipRxStream.Length;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state       <= IDLE;
            shiftReg    <= '0;
            byteIndex   <= '0;
            byteCount   <= '0;
            srcLatch    <= '0;
            opAddress   <= '0;
            opWriteData <= '0;
            opWrEnable  <= 1'b0;
`ifdef WRITE_ACK_EN
            addrByte    <= '0;
`endif
        end else begin
            opWrEnable <= 1'b0;
            if (state == IDLE || restartCmd) begin
                if (isReadCmd) begin
                    opAddress <= ipRxStream.Data[ADDR_WIDTH-1:0];
                    srcLatch  <= ipRxStream.Source;
                    state     <= READ_WAIT;
                end else if (isWriteCmd) begin
                    opAddress <= ipRxStream.Data[ADDR_WIDTH-1:0];
                    srcLatch  <= ipRxStream.Source;
                    byteCount <= '0;
`ifdef WRITE_ACK_EN
                    addrByte  <= ipRxStream.Data;
`endif
                    state     <= RX_WRITE;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    RX_WRITE: begin
                        if (ipRxStream.Valid) begin
                            if (byteCount == FULL_COUNT) begin
                                // Word already full and no EoP seen: oversize packet.
                                state <= IDLE;
                            end else begin
                                opWriteData <= shiftedWrite;
                                byteCount   <= countNext;
                                if (ipRxStream.EoP) begin
                                    if (countNext == FULL_COUNT) begin
                                        opWrEnable <= 1'b1;
                                        state      <= WRITE_COMMIT;
                                    end else begin
                                        state <= IDLE;
                                    end
                                end
                            end
                        end
                    end
                    READ_WAIT: state <= READ_LATCH;
                    READ_LATCH: begin
                        shiftReg  <= ipReadData;
                        byteIndex <= '0;
                        state     <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (ipTxReady) begin
                            if (byteIndex == LAST_INDEX) begin
                                state <= IDLE;
                            end else begin
                                shiftReg  <= shiftReg << 8;
                                byteIndex <= byteIndex + CNT_WIDTH'(1);
                            end
                        end
                    end
`ifdef WRITE_ACK_EN
                    WRITE_COMMIT: state <= TX_ACK;
                    TX_ACK: begin
                        if (ipTxReady) begin
                            state <= IDLE;
                        end
                    end
`else
                    WRITE_COMMIT: state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The response byte is a pure function of registered state, so it cannot
    // change while the transmitter stalls and drops to zero as soon as the
    // state leaves a transmit state (including on reset).
    always_comb begin
        opTxStream = '0;
        if (state == TX_DATA) begin
            opTxStream.Valid       = 1'b1;
            opTxStream.SoP         = (byteIndex == '0);
            opTxStream.EoP         = (byteIndex == LAST_INDEX);
            opTxStream.Source      = READ_DEST;
            opTxStream.Destination = srcLatch;
            opTxStream.Length      = 8'(DATA_BYTES);
            opTxStream.Data        = shiftReg[DATA_WIDTH-1 -: 8];
        end
`ifdef WRITE_ACK_EN
        else if (state == TX_ACK) begin
            opTxStream.Valid       = 1'b1;
            opTxStream.SoP         = 1'b1;
            opTxStream.EoP         = 1'b1;
            opTxStream.Source      = WRITE_DEST;
            opTxStream.Destination = srcLatch;
            opTxStream.Length      = 8'd1;
            opTxStream.Data        = addrByte;
        end
`endif
    end

endmodule

// File: tb/tb_register_access_controller.sv
// tb/tb_register_access_controller.sv - vector-driven bench for register_access_controller
module tb_register_access_controller;
    import uart_packet_pkg::*;

    logic       ipClk;
    logic       ipReset;
    UART_PACKET rxStream, txStream, rxStream2, txStream2;
    logic       txReady;
    logic [7:0] address, address2;
    logic [31:0] readData, writeData;
    logic [15:0] writeData2;
    logic       wrEnable, wrEnable2;

    int checks   = 0;
    int failures = 0;

    localparam UART_PACKET N = '0;

    register_access_controller #(.DATA_BYTES(4), .ADDR_WIDTH(8)) dut (
        .ipClk(ipClk), .ipReset(ipReset),
        .ipRxStream(rxStream), .opTxStream(txStream), .ipTxReady(txReady),
        .opAddress(address), .ipReadData(readData),
        .opWriteData(writeData), .opWrEnable(wrEnable)
    );

    register_access_controller #(.DATA_BYTES(2), .ADDR_WIDTH(8)) dut2 (
        .ipClk(ipClk), .ipReset(ipReset),
        .ipRxStream(rxStream2), .opTxStream(txStream2), .ipTxReady(txReady),
        .opAddress(address2), .ipReadData(readData[15:0]),
        .opWriteData(writeData2), .opWrEnable(wrEnable2)
    );

    initial begin
        ipClk = 1'b0;
        forever #5 ipClk = ~ipClk;
    end

    // Register file: data appears one cycle after the address.
    always @(posedge ipClk) begin
        readData <= (address == 8'h05) ? 32'hDEADBEEF
                                       : {address, ~address, address ^ 8'h0F, 8'h5A};
    end

    typedef struct {
        UART_PACKET rx;
        logic       ready;
        UART_PACKET expTx;
        logic       expWr;
        logic       chkReg;
        logic [7:0] expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    function automatic UART_PACKET rxB(input logic sop, input logic eop,
                                       input logic [7:0] src, input logic [7:0] dst,
                                       input logic [7:0] data);
        UART_PACKET p;
        p = '0;
        p.Valid = 1'b1; p.SoP = sop; p.EoP = eop;
        p.Source = src; p.Destination = dst; p.Data = data;
        return p;
    endfunction

    function automatic UART_PACKET txB(input logic sop, input logic eop,
                                       input logic [7:0] dst, input logic [7:0] data);
        UART_PACKET p;
        p = '0;
        p.Valid = 1'b1; p.SoP = sop; p.EoP = eop;
        p.Source = 8'h00; p.Destination = dst; p.Length = 8'd4; p.Data = data;
        return p;
    endfunction

    function automatic UART_PACKET ackB(input logic [7:0] dst, input logic [7:0] data);
        UART_PACKET p;
        p = '0;
        p.Valid = 1'b1; p.SoP = 1'b1; p.EoP = 1'b1;
        p.Source = 8'h01; p.Destination = dst; p.Length = 8'd1; p.Data = data;
        return p;
    endfunction

    function automatic UART_PACKET ackOrIdle(input logic [7:0] dst, input logic [7:0] data);
`ifdef WRITE_ACK_EN
        return ackB(dst, data);
`else
        return (dst == data) ? N : N;
`endif
    endfunction

    task automatic add(input UART_PACKET rx, input logic ready,
                       input UART_PACKET expTx, input logic expWr);
        vec_t v;
        v.rx = rx; v.ready = ready; v.expTx = expTx; v.expWr = expWr;
        v.chkReg = 1'b0; v.expAddr = '0; v.expData = '0;
        vecs.push_back(v);
    endtask

    task automatic addChk(input UART_PACKET expTx, input logic [7:0] addr,
                          input logic [31:0] data);
        vec_t v;
        v.rx = N; v.ready = 1'b1; v.expTx = expTx; v.expWr = 1'b0;
        v.chkReg = 1'b1; v.expAddr = addr; v.expData = data;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input UART_PACKET rx, input logic ready);
        @(negedge ipClk);
        rxStream = rx;
        txReady  = ready;
        #1;
    endtask

    int txSeen;

    initial begin
        ipReset   = 1'b1;
        rxStream  = N;
        rxStream2 = N;
        txReady   = 1'b0;

        // Read 0x05 from source 0x10, ready held high
        add(rxB(1, 1, 8'h10, 8'h00, 8'h05), 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, txB(1, 0, 8'h10, 8'hDE), 0);
        add(N, 1, txB(0, 0, 8'h10, 8'hAD), 0);
        add(N, 1, txB(0, 0, 8'h10, 8'hBE), 0);
        add(N, 1, txB(0, 1, 8'h10, 8'hEF), 0);
        add(N, 1, N, 0);
        // Same read with ready 1,0,0,1; a command arriving mid-response is dropped
        add(rxB(1, 1, 8'h10, 8'h00, 8'h05), 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, txB(1, 0, 8'h10, 8'hDE), 0);
        add(N, 0, txB(0, 0, 8'h10, 8'hAD), 0);
        add(rxB(1, 0, 8'h33, 8'h01, 8'h07), 0, txB(0, 0, 8'h10, 8'hAD), 0);
        add(N, 1, txB(0, 0, 8'h10, 8'hAD), 0);
        add(N, 1, txB(0, 0, 8'h10, 8'hBE), 0);
        add(N, 1, txB(0, 1, 8'h10, 8'hEF), 0);
        add(N, 0, N, 0);
        // Write 0x12345678 to address 7
        add(rxB(1, 0, 8'h33, 8'h01, 8'h07), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h12), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h34), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h56), 1, N, 0);
        add(rxB(0, 1, 8'h33, 8'h01, 8'h78), 1, N, 0);
        add(N, 1, N, 1);
        addChk(ackOrIdle(8'h33, 8'h07), 8'h07, 32'h12345678);
        // Early EoP: no strobe
        add(rxB(1, 0, 8'h33, 8'h01, 8'h09), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'hAA), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'hBB), 1, N, 0);
        add(rxB(0, 1, 8'h33, 8'h01, 8'hCC), 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, N, 0);
        // Five data bytes: no strobe
        add(rxB(1, 0, 8'h33, 8'h01, 8'h06), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h01), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h02), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h03), 1, N, 0);
        add(rxB(0, 0, 8'h33, 8'h01, 8'h04), 1, N, 0);
        add(rxB(0, 1, 8'h33, 8'h01, 8'h05), 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, N, 0);
        // Read 0x22 from source 0x44 after the dropped writes
        add(rxB(1, 1, 8'h44, 8'h00, 8'h22), 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, N, 0);
        add(N, 1, txB(1, 0, 8'h44, 8'h22), 0);
        add(N, 1, txB(0, 0, 8'h44, 8'hDD), 0);
        add(N, 1, txB(0, 0, 8'h44, 8'h2D), 0);
        add(N, 1, txB(0, 1, 8'h44, 8'h5A), 0);
        add(N, 1, N, 0);
        // SoP mid-write restarts with the new address
        add(rxB(1, 0, 8'h55, 8'h01, 8'h0B), 1, N, 0);
        add(rxB(0, 0, 8'h55, 8'h01, 8'h11), 1, N, 0);
        add(rxB(1, 0, 8'h55, 8'h01, 8'h0A), 1, N, 0);
        add(rxB(0, 0, 8'h55, 8'h01, 8'hCA), 1, N, 0);
        add(rxB(0, 0, 8'h55, 8'h01, 8'hFE), 1, N, 0);
        add(rxB(0, 0, 8'h55, 8'h01, 8'hF0), 1, N, 0);
        add(rxB(0, 1, 8'h55, 8'h01, 8'h0D), 1, N, 0);
        add(N, 1, N, 1);
        addChk(ackOrIdle(8'h55, 8'h0A), 8'h0A, 32'hCAFEF00D);

        repeat (3) @(negedge ipClk);
        #1;
        check("reset_tx", txStream, N);
        check("reset_addr", address, 8'h00);
        check("reset_wr", wrEnable, 1'b0);
        ipReset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rx, vecs[i].ready);
            check($sformatf("vec%0d_tx", i), txStream, vecs[i].expTx);
            check($sformatf("vec%0d_wr", i), wrEnable, vecs[i].expWr);
            if (vecs[i].chkReg) begin
                check($sformatf("vec%0d_addr", i), address, vecs[i].expAddr);
                check($sformatf("vec%0d_wdata", i), writeData, vecs[i].expData);
            end
        end

        // Reset while the third response byte is on the bus
        drive(rxB(1, 1, 8'h10, 8'h00, 8'h05), 1);
        drive(N, 1);
        drive(N, 1);
        drive(N, 1); check("rst_b0", txStream, txB(1, 0, 8'h10, 8'hDE));
        drive(N, 1); check("rst_b1", txStream, txB(0, 0, 8'h10, 8'hAD));
        drive(N, 1); check("rst_b2", txStream, txB(0, 0, 8'h10, 8'hBE));
        ipReset = 1'b1;
        drive(N, 1);
        check("rst_tx", txStream, N);
        check("rst_addr", address, 8'h00);
        check("rst_wdata", writeData, 32'h0);
        check("rst_wr", wrEnable, 1'b0);
        ipReset = 1'b0;
        txSeen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(N, 1);
            if (txStream.Valid) txSeen++;
        end
        check("rst_no_more_tx", txSeen, 0);

        // Two-byte instance: write {03, AB, CD}
        @(negedge ipClk); rxStream2 = rxB(1, 0, 8'h66, 8'h01, 8'h03);
        @(negedge ipClk); rxStream2 = rxB(0, 0, 8'h66, 8'h01, 8'hAB);
        @(negedge ipClk); rxStream2 = rxB(0, 1, 8'h66, 8'h01, 8'hCD);
        @(negedge ipClk); rxStream2 = N; #1;
        check("w2_wr", wrEnable2, 1'b1);
        check("w2_wdata", writeData2, 16'hABCD);
        check("w2_addr", address2, 8'h03);
        check("w2_tx_during_strobe", txStream2, N);
        @(negedge ipClk); #1;
        check("w2_wr_off", wrEnable2, 1'b0);
`ifdef WRITE_ACK_EN
        check("w2_ack", txStream2, ackB(8'h66, 8'h03));
        @(negedge ipClk); #1;
        check("w2_ack_done", txStream2, N);
`else
        check("w2_no_ack", txStream2, N);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_access_controller.md
# register_access_controller

Packet-level register access engine between the UART packetiser and the register file. Decodes received UART_PACKET streams into read and write transactions on a parametrised register bus. Reads return the register contents as a multi-byte response packet under a Valid/Ready handshake. Writes assemble a multi-byte word and commit it with a single-cycle strobe.

## Interface
- DATA_BYTES, 4: register width in bytes, range 1..8; bus width is 8*DATA_BYTES.
- ADDR_WIDTH, 8: register address width, range 1..8; address taken from the low bits of the address byte.
- READ_DEST, 8'h00: Destination value that selects a read command.
- WRITE_DEST, 8'h01: Destination value that selects a write command.
- ipClk  input  1  system clock; all logic on rising edge.
- ipReset  input  1  synchronous, active-high reset.
- ipRxStream  input  UART_PACKET  received bytes (Valid, SoP, EoP, Source, Destination, Length, Data); no backpressure.
- opTxStream  output  UART_PACKET  response bytes to the transmitter.
- ipTxReady  input  1  transmitter accepts opTxStream byte this cycle.
- opAddress  output  ADDR_WIDTH  register address.
- ipReadData  input  8*DATA_BYTES  register file read data, valid one cycle after opAddress.
- opWriteData  output  8*DATA_BYTES  write word.
- opWrEnable  output  1  one-cycle write strobe.

## Operation
- A byte is received on any cycle with ipRxStream.Valid=1. A byte is transmitted on any cycle with opTxStream.Valid=1 and ipTxReady=1.
- States: IDLE, RX_WRITE, READ_WAIT, READ_LATCH, TX_DATA, WRITE_COMMIT, and TX_ACK (TX_ACK exists only with the macro).
- IDLE transitions:
  - Byte with SoP=1, EoP=1 and Destination=READ_DEST: opAddress <= Data[ADDR_WIDTH-1:0], latch Source, go to READ_WAIT.
  - Byte with SoP=1, EoP=0 and Destination=WRITE_DEST: opAddress <= Data, byte counter <= 0, latch Source, go to RX_WRITE.
  - Any other byte is ignored.
- RX_WRITE:
  - Each received byte shifts into opWriteData MSB-first and increments the counter.
  - EoP on byte DATA_BYTES goes to WRITE_COMMIT.
  - EoP early, or more than DATA_BYTES bytes without EoP, drops the packet and returns to IDLE with no write.
  - SoP mid-packet restarts decoding from that byte as in IDLE.
- WRITE_COMMIT: opWrEnable=1 for exactly one cycle, then IDLE (or TX_ACK with the macro).
- READ_WAIT: one cycle for register file latency, then READ_LATCH.
- READ_LATCH: shift register <= ipReadData; byte index <= 0; go to TX_DATA.
- TX_DATA header fields:
  - opTxStream.Source = READ_DEST.
  - opTxStream.Destination = latched Source.
  - opTxStream.Length = DATA_BYTES.
- TX_DATA byte fields:
  - Data = shift register MSB byte.
  - SoP=1 only on index 0; EoP=1 only on index DATA_BYTES-1.
- TX_DATA handshake:
  - On a transfer, shift left 8 and increment the index.
  - After the transfer of index DATA_BYTES-1, Valid <= 0 and go to IDLE.
  - All opTxStream fields hold stable while Valid=1 and ipTxReady=0.
- Rx bytes arriving outside IDLE/RX_WRITE are discarded, not queued.
- The index and counter are $clog2(DATA_BYTES+1) bits wide and never wrap.

## Timing
- Reset values, one edge after ipReset is sampled high:
  - State IDLE.
  - opTxStream all fields 0, Valid=0.
  - opAddress=0, opWriteData=0, opWrEnable=0, counters 0.
- Reset mid-packet aborts immediately: no write strobe, and any partially sent response is abandoned with Valid=0.
- Read latency: read EoP byte at cycle T, opAddress valid in T+1, ipReadData sampled in T+2, first response byte Valid in T+3.
- With ipTxReady held high, a response occupies DATA_BYTES consecutive cycles.
- Write latency: final data byte at cycle T, opWrEnable=1 and opWriteData stable in T+1.
- opWriteData and opAddress hold their values after the strobe until the next command.
- ipTxReady is don't-care while Valid=0.

## Configuration
- WRITE_ACK_EN defined:
  - After WRITE_COMMIT, enter TX_ACK and send one byte: Source=WRITE_DEST, Destination=latched Source, Length=1, SoP=EoP=1, Data=address byte.
  - The byte is held until ipTxReady, then the block returns to IDLE.
- WRITE_ACK_EN undefined: TX_ACK is not built; writes are silent and WRITE_COMMIT returns directly to IDLE.

## Test plan
- Read, DATA_BYTES=4: read packet addr 8'h05, Source 8'h10; ipReadData=32'hDEADBEEF; Ready high -> bytes DE,AD,BE,EF on T+3..T+6, SoP on DE, EoP on EF, Destination 8'h10, Length 4.
- Backpressure: same read with ipTxReady toggling 1,0,0,1 -> each byte held stable while stalled; exactly 4 transfers, no duplicates.
- Write: packet {8'h07, 12, 34, 56, 78} to WRITE_DEST -> opWrEnable one cycle, opAddress 7, opWriteData 32'h12345678.
- Malformed write: EoP on third data byte -> no opWrEnable; a following read still responds correctly.
- Reset during TX_DATA after 2 bytes -> Valid 0 next cycle, state IDLE, no further bytes.
- DATA_BYTES=2 with WRITE_ACK_EN: write {8'h03, AB, CD} -> opWriteData 16'hABCD, then a one-byte ack with Data 8'h03.
